fetch_unit: RTL and testbench

- Instruction fetch front-end that sits directly upstream of the SimpleRISC decode/execute core.
- Owns the PC and issues word reads to an instruction memory over a valid/ready request and valid response interface.
- Buffers returned instructions, with their PCs, in a small queue that the core drains over a valid/ready handshake.
- Accepts branch/call/ret redirects from the core, flushes the queue and discards any stale in-flight response.

---
 rtl/fetch_unit.sv | 175 +++++++++++++++++
 tb/tb_fetch_unit.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front-end for the SimpleRISC core.
// Owns the PC and keeps at most one word read outstanding to instruction
// memory. Returned words are queued together with their PCs for the core.
// A redirect reloads the PC, flushes the queue and discards any stale
// in-flight response.
//
// Handshakes: each valid/ready pair transfers on a posedge where both are
// high. Valid never depends on its own ready. The response channel has no
// ready; a response is consumed in the cycle it is presented.
//
// Optional feature: define FETCH_STATS_EN to add the stat_fetched and
// stat_flushed saturating counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [1:0]  dbg_state
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_flushed
`endif
);

  localparam int unsigned AW = $clog2(QDEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(QDEPTH);

  // IDLE: may issue; WAIT: live response pending; DROP: stale response pending
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic          enq;
  logic          deq;

  logic [31:0]   data_mem [QDEPTH];
  logic [31:0]   pc_mem   [QDEPTH];

  assign inst_valid    = (count_q != '0);
  assign inst_out      = inst_valid ? data_mem[rd_q] : '0;
  assign inst_pc       = inst_valid ? pc_mem[rd_q]   : '0;
  assign imem_req_addr = pc_q;
  assign dbg_state     = state_q;

  // Fetch FSM: request issue, response acceptance/discard and PC update
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    req_pc_d       = req_pc_q;
    imem_req_valid = 1'b0;
    enq            = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // Gated by rst so no request is visible while reset is held.
        imem_req_valid = rst && (count_q < FULL) && !redirect_valid;
        if (imem_req_valid && imem_req_ready) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          enq     = !redirect_valid;
          state_d = S_IDLE;
        end else if (redirect_valid) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_rsp_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (redirect_valid) pc_d = redirect_pc & 32'hFFFF_FFFC;
  end

  assign deq = inst_valid && inst_ready && !redirect_valid;

  // Queue pointers and occupancy; a redirect empties the queue
  always_comb begin
    count_d = count_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    if (redirect_valid) begin
      count_d = '0;
      rd_d    = '0;
      wr_d    = '0;
    end else begin
      if (enq) wr_d = wr_q + 1'b1;
      if (deq) rd_d = rd_q + 1'b1;
      if (enq && !deq)      count_d = count_q + 1'b1;
      else if (!enq && deq) count_d = count_q - 1'b1;
    end
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      count_q  <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      count_q  <= count_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
    end
  end

  // Queue storage; contents are only observed while count is non-zero
  always_ff @(posedge clk) begin
    if (rst && enq) begin
      data_mem[wr_q] <= imem_rsp_data;
      pc_mem[wr_q]   <= req_pc_q;
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] fetched_q, fetched_d;
  logic [31:0] flushed_q, flushed_d;
  logic [32:0] flush_sum;

  // Saturating counters: words enqueued, and words thrown away by redirects
  // (queued entries plus a live response still owed by memory)
  always_comb begin
    fetched_d = fetched_q;
    flushed_d = flushed_q;
    flush_sum = {1'b0, flushed_q} + 33'(count_q) + 33'(state_q == S_WAIT);
    if (enq && (fetched_q != 32'hFFFF_FFFF)) fetched_d = fetched_q + 32'd1;
    if (redirect_valid) flushed_d = flush_sum[32] ? 32'hFFFF_FFFF : flush_sum[31:0];
  end

  // Statistics registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetched_q <= '0;
      flushed_q <= '0;
    end else begin
      fetched_q <= fetched_d;
      flushed_q <= flushed_d;
    end
  end

  assign stat_fetched = fetched_q;
  assign stat_flushed = flushed_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized traffic for fetch_unit,
// checked every cycle against a queue-based behavioural model.
module tb_fetch_unit;

  localparam int          QDEPTH   = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [1:0]  dbg_state;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched;
  logic [31:0] stat_flushed;
`endif

  fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dbg_state      (dbg_state)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched   (stat_fetched),
    .stat_flushed   (stat_flushed)
`endif
  );

  // ---------------- stimulus knobs ----------------
  logic        rst_k, irdy_k, mrdy_k, redir_k;
  logic [31:0] redir_pc_k;
  int          lat_k;

  // ---------------- memory model ----------------
  bit          mem_pend;
  logic [31:0] mem_addr;
  int          mem_wait;

  // ---------------- reference model ----------------
  bit          m_ready;
  logic [31:0] m_pc;
  logic [31:0] m_req_pc;
  int          m_out;          // 0 none, 1 live response owed, 2 stale response owed
  logic [63:0] exp_q[$];       // {pc, data} expected on inst_* in order
`ifdef FETCH_STATS_EN
  logic [31:0] m_fetched, m_flushed;
  logic [32:0] m_sum;
`endif

  // observation logs for literal checks
  logic [31:0] acc_log[$];
  logic [31:0] pop_pc_log[$];
  bit          dut_acc, dut_pop;
  logic [31:0] acc_addr_s, pop_pc_s;
  bit          exp_rv_c, exp_rv_m;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply();
    rst            = rst_k;
    inst_ready     = irdy_k;
    redirect_valid = redir_k;
    redirect_pc    = redir_pc_k;
    imem_req_ready = mrdy_k && !mem_pend;
    imem_rsp_valid = mem_pend && (mem_wait == 0);
    imem_rsp_data  = imem_rsp_valid ? mem_word(mem_addr) : $urandom();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    apply();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset(input int n);
    rst_k = 1'b0;
    redir_k = 1'b0;
    run(n);
    rst_k = 1'b1;
  endtask

  task automatic clear_logs();
    acc_log.delete();
    pop_pc_log.delete();
  endtask

  // ---------------- compare process (away from the active edge) ----------------
  always @(negedge clk) begin
    dut_acc    = imem_req_valid && imem_req_ready;
    acc_addr_s = imem_req_addr;
    dut_pop    = inst_valid && inst_ready && rst && !redirect_valid;
    pop_pc_s   = inst_pc;
    if (m_ready) begin
      exp_rv_c = rst && (m_out == 0) && (exp_q.size() < QDEPTH) && !redirect_valid;
      check("req_valid", imem_req_valid, exp_rv_c);
      if (exp_rv_c) check("req_addr", imem_req_addr, m_pc);
      check("inst_valid", inst_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        check("inst_pc", inst_pc, exp_q[0][63:32]);
        check("inst_out", inst_out, exp_q[0][31:0]);
      end else if (!rst) begin
        check("reset_inst_pc", inst_pc, 32'h0);
        check("reset_inst_out", inst_out, 32'h0);
      end
`ifdef FETCH_STATS_EN
      check("stat_fetched", stat_fetched, m_fetched);
      check("stat_flushed", stat_flushed, m_flushed);
`endif
    end
  end

  // ---------------- memory + model update at the active edge ----------------
  always @(posedge clk) begin
    if (imem_rsp_valid) mem_pend = 1'b0;
    else if (mem_pend) mem_wait--;
    if (dut_acc) begin
      mem_pend = 1'b1;
      mem_addr = acc_addr_s;
      mem_wait = lat_k - 1;
      acc_log.push_back(acc_addr_s);
    end
    if (dut_pop) pop_pc_log.push_back(pop_pc_s);

    if (!rst) begin
      m_ready = 1'b1;
      m_pc    = RESET_PC;
      m_out   = 0;
      exp_q.delete();
`ifdef FETCH_STATS_EN
      m_fetched = '0;
      m_flushed = '0;
`endif
    end else if (m_ready) begin
      exp_rv_m = (m_out == 0) && (exp_q.size() < QDEPTH) && !redirect_valid;
      if (redirect_valid) begin
`ifdef FETCH_STATS_EN
        m_sum = {1'b0, m_flushed} + 33'(exp_q.size()) + 33'(m_out == 1);
        m_flushed = m_sum[32] ? 32'hFFFF_FFFF : m_sum[31:0];
`endif
        exp_q.delete();
        if (imem_rsp_valid) m_out = 0;
        else if (m_out == 1) m_out = 2;
        m_pc = {redirect_pc[31:2], 2'b00};
      end else begin
        if (inst_ready && exp_q.size() != 0) void'(exp_q.pop_front());
        if (imem_rsp_valid && m_out != 0) begin
          if (m_out == 1) begin
            exp_q.push_back({m_req_pc, imem_rsp_data});
`ifdef FETCH_STATS_EN
            if (m_fetched != 32'hFFFF_FFFF) m_fetched = m_fetched + 1;
`endif
          end
          m_out = 0;
        end
        if (exp_rv_m && imem_req_ready) begin
          m_req_pc = m_pc;
          m_pc     = m_pc + 32'd4;
          m_out    = 1;
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scenarios ----------------
  initial begin : main
    int          found;
    int          hits;
    logic [31:0] dropped_pc;

    rst_k = 1'b0; irdy_k = 1'b0; mrdy_k = 1'b1; redir_k = 1'b0;
    redir_pc_k = '0; lat_k = 1;
    apply();

    // 1: streaming with 1-cycle memory and an always-ready core
    do_reset(3);
    check("t1_dbg_state_idle", dbg_state, 32'd0);
    irdy_k = 1'b1; lat_k = 1;
    clear_logs();
    run(20);
    check("t1_pop_count_ge4", pop_pc_log.size() >= 4, 1);
    for (int i = 0; i < 4 && i < pop_pc_log.size(); i++)
      check("t1_pc_seq", pop_pc_log[i], RESET_PC + 32'(4 * i));

    // 2: stalled core fills the queue, a single pop lets one request out
    do_reset(2);
    irdy_k = 1'b0;
    clear_logs();
    run(20);
    check("t2_req_count", acc_log.size(), 4);
    if (acc_log.size() == 4) check("t2_last_addr", acc_log[3], 32'h0000_000C);
    check("t2_req_valid_full", imem_req_valid, 0);
    irdy_k = 1'b1;
    step();
    irdy_k = 1'b0;
    run(6);
    check("t2_req_count_after_pop", acc_log.size(), 5);
    if (acc_log.size() == 5) check("t2_refill_addr", acc_log[4], 32'h0000_0010);
    check("t2_single_pop", pop_pc_log.size(), 1);

    // 3: redirect while a slow response is outstanding
    do_reset(2);
    irdy_k = 1'b1; lat_k = 4;
    found = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (m_out == 1 && mem_pend && mem_wait >= 2) begin found = 1; break; end
    end
    check("t3_found_wait", found, 1);
    redir_k = 1'b1; redir_pc_k = 32'h0000_0103;
    apply();
    redir_k = 1'b0;
    clear_logs();
    step();
    check("t3_flushed_empty", inst_valid, 0);
    lat_k = 1;
    run(30);
    check("t3_acc_nonempty", acc_log.size() != 0, 1);
    if (acc_log.size() != 0) check("t3_first_addr", acc_log[0], 32'h0000_0100);
    check("t3_pop_nonempty", pop_pc_log.size() != 0, 1);
    if (pop_pc_log.size() != 0) check("t3_first_pc", pop_pc_log[0], 32'h0000_0100);

    // 4: redirect in the same cycle as a response
    do_reset(2);
    irdy_k = 1'b0; lat_k = 2;
    run(5);
    found = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (mem_pend && mem_wait == 0) begin found = 1; break; end
    end
    check("t4_found_rsp", found, 1);
    dropped_pc = mem_addr;
    redir_k = 1'b1; redir_pc_k = 32'h0000_0200;
    apply();
    redir_k = 1'b0;
    clear_logs();
    irdy_k = 1'b1;
    run(20);
    if (acc_log.size() != 0) check("t4_first_addr", acc_log[0], 32'h0000_0200);
    if (pop_pc_log.size() != 0) check("t4_first_pc", pop_pc_log[0], 32'h0000_0200);
    hits = 0;
    foreach (pop_pc_log[i]) if (pop_pc_log[i] == dropped_pc) hits++;
    check("t4_dropped_absent", hits, 0);

    // 5: reset while waiting, stale response arrives after release
    do_reset(2);
    irdy_k = 1'b1; lat_k = 4;
    found = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (m_out == 1) begin found = 1; break; end
    end
    check("t5_found_wait", found, 1);
    rst_k = 1'b0;
    apply();
    clear_logs();
    step();
    rst_k = 1'b1;
    step();
    step();
    step();
    check("t5_late_rsp_ignored", inst_valid, 0);
    lat_k = 1;
    run(10);
    if (acc_log.size() != 0) check("t5_first_addr", acc_log[0], RESET_PC);
    if (pop_pc_log.size() != 0) check("t5_first_pc", pop_pc_log[0], RESET_PC);

`ifdef FETCH_STATS_EN
    // 6: statistics after three queued words and one in flight
    do_reset(2);
    irdy_k = 1'b0; lat_k = 2;
    found = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (exp_q.size() == 3 && m_out == 1) begin found = 1; break; end
    end
    check("t6_found", found, 1);
    redir_k = 1'b1; redir_pc_k = 32'h0000_0300;
    apply();
    redir_k = 1'b0;
    step();
    check("t6_stat_fetched", stat_fetched, 32'd3);
    check("t6_stat_flushed", stat_flushed, 32'd4);
`endif

    // 7: randomized traffic, redirects and occasional resets
    do_reset(2);
    for (int i = 0; i < 1500; i++) begin
      irdy_k     = ($urandom_range(0, 3) != 0);
      mrdy_k     = ($urandom_range(0, 3) != 0);
      lat_k      = $urandom_range(1, 4);
      redir_k    = ($urandom_range(0, 15) == 0);
      redir_pc_k = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF6 : $urandom();
      rst_k      = ($urandom_range(0, 199) != 0);
      step();
    end
    rst_k = 1'b1; redir_k = 1'b0; mrdy_k = 1'b1; irdy_k = 1'b1;
    run(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
